// File: rtl/vend_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vend_req_arbiter_if
// Purpose  : Operation-mode port between the request arbiter and the vending
//            core. The arbiter presents one purchase (item + amount) and the
//            core answers with a one-cycle dispense result strobe.
// Signals  : item_select[9:0], item_select_valid, currency_value[7:0]
//              (arbiter -> core)
//            item_dispense_valid, item_dispense[9:0], currency_change[7:0]
//              (core -> arbiter)
// Modports : master = arbiter side, slave = core side
// Revision : 1.0 - initial release
// ============================================================================
interface vend_req_arbiter_if;
    logic [9:0] item_select;
    logic       item_select_valid;
    logic [7:0] currency_value;
    logic       item_dispense_valid;
    logic [9:0] item_dispense;
    logic [7:0] currency_change;

    modport master (
        output item_select,
        output item_select_valid,
        output currency_value,
        input  item_dispense_valid,
        input  item_dispense,
        input  currency_change
    );

    modport slave (
        input  item_select,
        input  item_select_valid,
        input  currency_value,
        output item_dispense_valid,
        output item_dispense,
        output currency_change
    );
endinterface
`default_nettype wire

// File: rtl/vend_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vend_req_arbiter
// Purpose  : Grants up to NREQ customer panels one at a time onto the vending
//            core's operation-mode port, waits for the dispense result (or a
//            timeout), and returns the result to the granted panel. No new
//            grant is issued while cfg_mode is high.
// Ports    : pclk, prstn (async active-low)       clock / reset
//            cfg_mode                             blocks new grants
//            req, req_item, req_amount            per-panel request inputs
//            grant, ack, rsp_item, rsp_change,    per-panel result outputs
//            busy, timeout
//            core (vend_req_arbiter_if.master)    core operation-mode port
// Params   : NREQ (2..8), TIMEOUT_CYC (2..65535)
// Options  : VEND_ARB_PRIO_EN - requester 0 gets fixed top priority and the
//            round-robin pointer only rotates over requesters 1..NREQ-1.
// Revision : 1.0 - initial release
// ============================================================================
module vend_req_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 pclk,
    input  logic                 prstn,
    input  logic                 cfg_mode,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*10-1:0]   req_item,
    input  logic [NREQ*8-1:0]    req_amount,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      ack,
    output logic [9:0]           rsp_item,
    output logic [7:0]           rsp_change,
    output logic                 busy,
    output logic                 timeout,
    vend_req_arbiter_if.master   core
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

`ifdef VEND_ARB_PRIO_EN
    localparam int         POOL = NREQ - 1;  // requesters 1..NREQ-1 share the pointer
    localparam logic [2:0] BASE = 3'd1;
`else
    localparam int         POOL = NREQ;
    localparam logic [2:0] BASE = 3'd0;
`endif
    // Timer value in the last WAIT cycle before abort, so the abort ack lands
    // exactly TIMEOUT_CYC cycles after the ISSUE cycle.
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 2);

    state_t          state_q;
    logic [2:0]      ptr_q;
    logic [2:0]      winner_q;
    logic [15:0]     timer_q;
    logic [7:0]      amount_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] ack_q;
    logic [9:0]      rsp_item_q;
    logic [7:0]      rsp_change_q;
    logic            busy_q;
    logic            timeout_q;
    logic [9:0]      isel_q;
    logic            isel_valid_q;
    logic [7:0]      cur_q;

    logic [POOL-1:0] pool_w;
    logic [POOL-1:0] hi_w;
    logic [2:0]      off_w;
    logic [2:0]      first_hi_w;
    logic [2:0]      first_lo_w;
    logic [2:0]      win_w;
    logic            any_w;
    logic [NREQ-1:0] onehot_w;
    logic [9:0]      item_w;
    logic [7:0]      amt_w;
    logic [2:0]      ptr_next_w;

    // Round-robin pick: lowest requester at or above the pointer offset wins;
    // if none, wrap to the lowest requester overall.
    always_comb begin
`ifdef VEND_ARB_PRIO_EN
        pool_w = req[NREQ-1:1];
        off_w  = (ptr_q == 3'd0) ? 3'd0 : ptr_q - 3'd1;
`else
        pool_w = req;
        off_w  = ptr_q;
`endif
        hi_w       = '0;
        first_hi_w = '0;
        first_lo_w = '0;
        for (int i = 0; i < POOL; i++) begin
            hi_w[i] = pool_w[i] && (3'(i) >= off_w);
        end
        for (int i = POOL - 1; i >= 0; i--) begin
            if (hi_w[i])   first_hi_w = 3'(i);
            if (pool_w[i]) first_lo_w = 3'(i);
        end
        win_w = BASE + ((|hi_w) ? first_hi_w : first_lo_w);
        any_w = |pool_w;
`ifdef VEND_ARB_PRIO_EN
        if (req[0]) begin
            win_w = 3'd0;
            any_w = 1'b1;
        end
`endif
    end

    always_comb begin
        onehot_w = '0;
        item_w   = '0;
        amt_w    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_w == 3'(i)) begin
                onehot_w[i] = 1'b1;
                item_w      = req_item[i*10 +: 10];
                amt_w       = req_amount[i*8 +: 8];
            end
        end
    end

    always_comb begin
`ifdef VEND_ARB_PRIO_EN
        // The fixed-priority requester never moves the pointer.
        if (winner_q == 3'd0)
            ptr_next_w = ptr_q;
        else if (winner_q == 3'(NREQ - 1))
            ptr_next_w = 3'd1;
        else
            ptr_next_w = winner_q + 3'd1;
`else
        ptr_next_w = (winner_q == 3'(NREQ - 1)) ? 3'd0 : winner_q + 3'd1;
`endif
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            winner_q     <= '0;
            timer_q      <= '0;
            amount_q     <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            rsp_item_q   <= '0;
            rsp_change_q <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            isel_q       <= '0;
            isel_valid_q <= 1'b0;
            cur_q        <= '0;
        end else begin
            ack_q     <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!cfg_mode && any_w) begin
                        grant_q      <= onehot_w;
                        winner_q     <= win_w;
                        isel_q       <= item_w;
                        amount_q     <= amt_w;
                        cur_q        <= amt_w;
                        isel_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cur_q   <= '0;
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving together with the timeout wins.
                    if (core.item_dispense_valid) begin
                        rsp_item_q   <= core.item_dispense;
                        rsp_change_q <= core.currency_change;
                        ack_q        <= grant_q;
                        isel_valid_q <= 1'b0;
                        isel_q       <= '0;
                        state_q      <= S_DONE;
                    end else if (timer_q == TIMER_LAST) begin
                        rsp_item_q   <= 10'd1023;
                        rsp_change_q <= amount_q;
                        ack_q        <= grant_q;
                        timeout_q    <= 1'b1;
                        isel_valid_q <= 1'b0;
                        isel_q       <= '0;
                        state_q      <= S_DONE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_DONE: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ptr_next_w;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant                  = grant_q;
    assign ack                    = ack_q;
    assign rsp_item               = rsp_item_q;
    assign rsp_change             = rsp_change_q;
    assign busy                   = busy_q;
    assign timeout                = timeout_q;
    assign core.item_select       = isel_q;
    assign core.item_select_valid = isel_valid_q;
    assign core.currency_value    = cur_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_req_arbiter
// Purpose  : Directed self-checking bench for vend_req_arbiter (NREQ=4,
//            TIMEOUT_CYC=16). The bench plays the vending core through the
//            interface instance and checks hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_req_arbiter;
    localparam int NREQ = 4;
    localparam int TCYC = 16;

    logic        pclk = 1'b0;
    logic        prstn;
    logic        cfg_mode;
    logic [3:0]  req;
    logic [39:0] req_item;
    logic [31:0] req_amount;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [9:0]  rsp_item;
    logic [7:0]  rsp_change;
    logic        busy;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    vend_req_arbiter_if u_if();

    vend_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TCYC)) dut (
        .pclk       (pclk),
        .prstn      (prstn),
        .cfg_mode   (cfg_mode),
        .req        (req),
        .req_item   (req_item),
        .req_amount (req_amount),
        .grant      (grant),
        .ack        (ack),
        .rsp_item   (rsp_item),
        .rsp_change (rsp_change),
        .busy       (busy),
        .timeout    (timeout),
        .core       (u_if)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic core_idle();
        u_if.item_dispense_valid = 1'b0;
        u_if.item_dispense       = '0;
        u_if.currency_change     = '0;
    endtask

    task automatic do_reset();
        prstn = 1'b0; req = '0; cfg_mode = 1'b0;
        core_idle();
        tick(); tick();
        prstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        prstn = 1'b0; req = '0; cfg_mode = 1'b0; req_item = '0; req_amount = '0;
        core_idle();
        tick(); tick();
        n_cmp++;
        if ({grant, ack, busy, timeout} !== 10'd0) begin
            n_err++; $display("FAIL reset_ctrl: grant/ack/busy/timeout=%b want 0", {grant, ack, busy, timeout});
        end
        n_cmp++;
        if ({rsp_item, rsp_change} !== 18'd0) begin
            n_err++; $display("FAIL reset_rsp: rsp_item=%0d rsp_change=%0d want 0/0", rsp_item, rsp_change);
        end
        n_cmp++;
        if ({u_if.item_select, u_if.item_select_valid, u_if.currency_value} !== 19'd0) begin
            n_err++; $display("FAIL reset_core: isel=%0d valid=%b cur=%0d want 0", u_if.item_select, u_if.item_select_valid, u_if.currency_value);
        end
        prstn = 1'b1;
        tick();
        n_cmp++;
        if ({grant, busy} !== 5'd0) begin
            n_err++; $display("FAIL reset_idle: grant=%b busy=%b want 0", grant, busy);
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        req_item[20 +: 10] = 10'd5;
        req_amount[16 +: 8] = 8'd40;
        req = 4'b0100;
        tick();                                   // ISSUE
        n_cmp++;
        if (grant !== 4'b0100 || busy !== 1'b1) begin
            n_err++; $display("FAIL single_grant: grant=%b busy=%b want 0100/1", grant, busy);
        end
        n_cmp++;
        if (u_if.item_select !== 10'd5 || u_if.item_select_valid !== 1'b1 || u_if.currency_value !== 8'd40) begin
            n_err++; $display("FAIL single_issue: isel=%0d valid=%b cur=%0d want 5/1/40", u_if.item_select, u_if.item_select_valid, u_if.currency_value);
        end
        tick();                                   // WAIT
        n_cmp++;
        if (u_if.item_select !== 10'd5 || u_if.item_select_valid !== 1'b1 || u_if.currency_value !== 8'd0 || ack !== 4'b0) begin
            n_err++; $display("FAIL single_wait: isel=%0d valid=%b cur=%0d ack=%b want 5/1/0/0000", u_if.item_select, u_if.item_select_valid, u_if.currency_value, ack);
        end
        u_if.item_dispense_valid = 1'b1; u_if.item_dispense = 10'd5; u_if.currency_change = 8'd10;
        tick();                                   // DONE
        n_cmp++;
        if (ack !== 4'b0100 || rsp_item !== 10'd5 || rsp_change !== 8'd10 || timeout !== 1'b0) begin
            n_err++; $display("FAIL single_ack: ack=%b rsp=%0d/%0d to=%b want 0100 5/10 0", ack, rsp_item, rsp_change, timeout);
        end
        core_idle();
        req = '0;
        tick();                                   // IDLE
        n_cmp++;
        if (ack !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL single_release: ack=%b grant=%b busy=%b want 0", ack, grant, busy);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_item[k*10 +: 10] = 10'(100 + k);
            req_amount[k*8 +: 8] = 8'(10 * (k + 1));
        end
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();                               // ISSUE
            n_cmp++;
            if (grant !== 4'(1 << k) || u_if.item_select !== 10'(100 + k)) begin
                n_err++; $display("FAIL fair_grant%0d: grant=%b isel=%0d want %b/%0d", k, grant, u_if.item_select, 4'(1 << k), 100 + k);
            end
            tick();                               // WAIT
            u_if.item_dispense_valid = 1'b1; u_if.item_dispense = 10'(k); u_if.currency_change = 8'(k);
            tick();                               // DONE
            n_cmp++;
            if (ack !== 4'(1 << k) || rsp_item !== 10'(k)) begin
                n_err++; $display("FAIL fair_ack%0d: ack=%b rsp_item=%0d want %b/%0d", k, ack, rsp_item, 4'(1 << k), k);
            end
            core_idle();
            req[k] = 1'b0;
            tick();                               // IDLE between back-to-back grants
            n_cmp++;
            if (grant !== 4'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL b2b_idle%0d: grant=%b busy=%b want 0", k, grant, busy);
            end
        end
    endtask

`ifdef VEND_ARB_PRIO_EN
    task automatic test_prio();
        int exp_w [6] = '{0, 1, 0, 2, 0, 3};
        do_reset();
        req = 4'b1111;
        for (int s = 0; s < 6; s++) begin
            tick();
            n_cmp++;
            if (grant !== 4'(1 << exp_w[s])) begin
                n_err++; $display("FAIL prio_grant%0d: grant=%b want %b", s, grant, 4'(1 << exp_w[s]));
            end
            tick();
            u_if.item_dispense_valid = 1'b1;
            tick();
            core_idle();
            req[exp_w[s]] = 1'b0;
            if (exp_w[s] != 0 && s < 5) req[0] = 1'b1;
            tick();
        end
        req = '0;
    endtask
`endif

    task automatic test_timeout();
        logic early;
        do_reset();
        req_item[10 +: 10] = 10'd7;
        req_amount[8 +: 8] = 8'd55;
        req = 4'b0010;
        tick();                                   // ISSUE cycle = reference
        n_cmp++;
        if (grant !== 4'b0010 || u_if.currency_value !== 8'd55) begin
            n_err++; $display("FAIL to_grant: grant=%b cur=%0d want 0010/55", grant, u_if.currency_value);
        end
        early = 1'b0;
        for (int n = 1; n < TCYC; n++) begin
            tick();
            if (ack !== 4'b0 || timeout !== 1'b0) early = 1'b1;
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_err++; $display("FAIL to_early: early ack/timeout seen=%b want 0", early);
        end
        tick();                                   // TCYC cycles after ISSUE
        n_cmp++;
        if (ack !== 4'b0010 || timeout !== 1'b1) begin
            n_err++; $display("FAIL to_ack: ack=%b timeout=%b want 0010/1", ack, timeout);
        end
        n_cmp++;
        if (rsp_item !== 10'd1023 || rsp_change !== 8'd55) begin
            n_err++; $display("FAIL to_rsp: rsp=%0d/%0d want 1023/55", rsp_item, rsp_change);
        end
        req = '0;
        tick();
        n_cmp++;
        if (timeout !== 1'b0 || ack !== 4'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL to_pulse: timeout=%b ack=%b busy=%b want 0", timeout, ack, busy);
        end
    endtask

    task automatic test_cfg_block();
        logic seen;
        do_reset();
        cfg_mode = 1'b1;
        req = 4'b0010;
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (grant !== 4'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL cfg_block: grant/busy seen under cfg_mode=%b want 0", seen);
        end
        cfg_mode = 1'b0;
        tick();                                   // ISSUE
        n_cmp++;
        if (grant !== 4'b0010 || busy !== 1'b1) begin
            n_err++; $display("FAIL cfg_release: grant=%b busy=%b want 0010/1", grant, busy);
        end
        tick();                                   // WAIT
        cfg_mode = 1'b1;
        tick();                                   // still WAIT
        u_if.item_dispense_valid = 1'b1; u_if.item_dispense = 10'd7; u_if.currency_change = 8'd3;
        tick();                                   // DONE
        n_cmp++;
        if (ack !== 4'b0010 || rsp_item !== 10'd7 || rsp_change !== 8'd3) begin
            n_err++; $display("FAIL cfg_midwait: ack=%b rsp=%0d/%0d want 0010 7/3", ack, rsp_item, rsp_change);
        end
        core_idle();
        req = 4'b1000;
        tick(); tick();
        n_cmp++;
        if (grant !== 4'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL cfg_next_block: grant=%b busy=%b want 0", grant, busy);
        end
        req = '0;
        cfg_mode = 1'b0;
        tick();
    endtask

    task automatic test_stray_and_reset();
        logic seen;
        u_if.item_dispense_valid = 1'b1; u_if.item_dispense = 10'd9; u_if.currency_change = 8'd9;
        tick();
        core_idle();
        n_cmp++;
        if (ack !== 4'b0 || busy !== 1'b0 || grant !== 4'b0) begin
            n_err++; $display("FAIL stray: ack=%b busy=%b grant=%b want 0", ack, busy, grant);
        end
        req_item[0 +: 10] = 10'd2;
        req_amount[0 +: 8] = 8'd20;
        req = 4'b0001;
        tick();                                   // ISSUE
        n_cmp++;
        if (grant !== 4'b0001) begin
            n_err++; $display("FAIL rst_pre_grant: grant=%b want 0001", grant);
        end
        tick();                                   // WAIT
        #2 prstn = 1'b0;
        #1;
        n_cmp++;
        if ({grant, ack, busy, timeout, rsp_item, rsp_change, u_if.item_select, u_if.item_select_valid, u_if.currency_value} !== 47'd0) begin
            n_err++; $display("FAIL rst_async: grant=%b busy=%b valid=%b isel=%0d want all 0", grant, busy, u_if.item_select_valid, u_if.item_select);
        end
        req = '0;
        tick();
        prstn = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (ack !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL rst_no_ack: activity after reset release=%b want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_fairness();
`ifdef VEND_ARB_PRIO_EN
        test_prio();
`endif
        test_timeout();
        test_cfg_block();
        test_stray_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
